seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 209 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential MIPS-style ALU: single-cycle logic/arithmetic ops plus iterative
// multiply and restoring divide sharing one 2*WIDTH shift register.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] value1,
   input  logic [WIDTH-1:0] value2,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic             divzero,
   output logic             illegal
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [5:0] OP_RTYPE = 6'd0,  OP_ADDI  = 6'd8,  OP_ADDIU = 6'd9,
                          OP_SLTI  = 6'd10, OP_SLTIU = 6'd11, OP_ANDI  = 6'd12,
                          OP_ORI   = 6'd13, OP_XORI  = 6'd14;
   localparam logic [5:0] FN_MFHI = 6'd16, FN_MFLO = 6'd18, FN_MULT = 6'd24,
                          FN_MULTU = 6'd25, FN_DIV = 6'd26, FN_DIVU = 6'd27,
                          FN_ADD  = 6'd32, FN_ADDU = 6'd33, FN_SUB  = 6'd34,
                          FN_SUBU = 6'd35, FN_AND  = 6'd36, FN_OR   = 6'd37,
                          FN_XOR  = 6'd38, FN_NOR  = 6'd39, FN_SLT  = 6'd42,
                          FN_SLTU = 6'd43;

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     hi_q, lo_q;
   logic [2*WIDTH-1:0]   acc_q;      // MUL: {partial, multiplier}; DIV: {remainder, dividend/quotient}
   logic [WIDTH-1:0]     opb_q;      // multiplicand or divisor magnitude
   logic [WIDTH-1:0]     dvd_q;
   logic [CW-1:0]        cnt_q;
   logic                 neg_res_q, neg_rem_q, dz_q;
   logic                 out_valid_q, ovf_q, divzero_q, illegal_q;
   logic [WIDTH-1:0]     result_q;

   logic [WIDTH-1:0]     sum, diff, alu_res, abs_a, abs_b;
   logic                 slt_s, slt_u, add_ovf, sub_ovf;
   logic                 alu_ovf, alu_ill, start_mul, start_div, op_signed;

   logic [WIDTH:0]       mul_sum, div_shift;
   logic [WIDTH-1:0]     div_trial, div_quo, div_rem;
   logic [2*WIDTH-1:0]   mul_next, mul_fix, div_next;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign ovf       = ovf_q;
   assign divzero   = divzero_q;
   assign illegal   = illegal_q;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      sum       = value1 + value2;
      diff      = value1 - value2;
      slt_s     = $signed(value1) < $signed(value2);
      slt_u     = value1 < value2;
      add_ovf   = (value1[WIDTH-1] == value2[WIDTH-1]) && (sum[WIDTH-1] != value1[WIDTH-1]);
      sub_ovf   = (value1[WIDTH-1] != value2[WIDTH-1]) && (diff[WIDTH-1] != value1[WIDTH-1]);
      alu_res   = '0;
      alu_ovf   = 1'b0;
      alu_ill   = 1'b0;
      start_mul = 1'b0;
      start_div = 1'b0;
      op_signed = 1'b0;
      if (opcode == OP_RTYPE) begin
         case (func)
            FN_ADD:   begin alu_res = sum;  alu_ovf = add_ovf; end
            FN_ADDU:  alu_res = sum;
            FN_SUB:   begin alu_res = diff; alu_ovf = sub_ovf; end
            FN_SUBU:  alu_res = diff;
            FN_AND:   alu_res = value1 & value2;
            FN_OR:    alu_res = value1 | value2;
            FN_XOR:   alu_res = value1 ^ value2;
            FN_NOR:   alu_res = ~(value1 | value2);
            FN_SLT:   alu_res = {{(WIDTH-1){1'b0}}, slt_s};
            FN_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, slt_u};
            FN_MFHI:  alu_res = hi_q;
            FN_MFLO:  alu_res = lo_q;
            FN_MULT:  begin start_mul = 1'b1; op_signed = 1'b1; end
            FN_MULTU: start_mul = 1'b1;
            FN_DIV:   begin start_div = 1'b1; op_signed = 1'b1; end
            FN_DIVU:  start_div = 1'b1;
            default:  alu_ill = 1'b1;
         endcase
      end else begin
         case (opcode)
            OP_ADDI:  begin alu_res = sum; alu_ovf = add_ovf; end
            OP_ADDIU: alu_res = sum;
            OP_SLTI:  alu_res = {{(WIDTH-1){1'b0}}, slt_s};
            OP_SLTIU: alu_res = {{(WIDTH-1){1'b0}}, slt_u};
            OP_ANDI:  alu_res = value1 & value2;
            OP_ORI:   alu_res = value1 | value2;
            OP_XORI:  alu_res = value1 ^ value2;
            default:  alu_ill = 1'b1;
         endcase
      end
      abs_a = (op_signed && value1[WIDTH-1]) ? -value1 : value1;
      abs_b = (op_signed && value2[WIDTH-1]) ? -value2 : value2;
   end

   // One iteration of shift-add multiply / restoring divide, plus the sign fix-up
   // applied on the final iteration.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      mul_fix   = neg_res_q ? -mul_next : mul_next;
      div_shift = acc_q[2*WIDTH-1:WIDTH-1];
      div_trial = div_shift[WIDTH-1:0] - opb_q;
      if (div_shift >= {1'b0, opb_q})
         div_next = {div_trial, acc_q[WIDTH-2:0], 1'b1};
      else
         div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      div_quo = neg_res_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
      div_rem = neg_rem_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
      if (dz_q) begin
         div_quo = '1;
         div_rem = dvd_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         hi_q        <= '0;
         lo_q        <= '0;
         acc_q       <= '0;
         opb_q       <= '0;
         dvd_q       <= '0;
         cnt_q       <= '0;
         neg_res_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         dz_q        <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         ovf_q       <= 1'b0;
         divzero_q   <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  cnt_q     <= CW'(WIDTH-1);
                  neg_res_q <= op_signed && (value1[WIDTH-1] ^ value2[WIDTH-1]);
                  neg_rem_q <= op_signed && value1[WIDTH-1];
                  if (start_mul) begin
                     state_q <= MUL;
                     acc_q   <= {{WIDTH{1'b0}}, abs_b};
                     opb_q   <= abs_a;
                  end else if (start_div) begin
                     state_q <= DIV;
                     acc_q   <= {{WIDTH{1'b0}}, abs_a};
                     opb_q   <= abs_b;
                     dvd_q   <= value1;
                     dz_q    <= (value2 == '0);
                  end else begin
                     out_valid_q <= 1'b1;
                     result_q    <= alu_res;
                     ovf_q       <= alu_ovf;
                     divzero_q   <= 1'b0;
                     illegal_q   <= alu_ill;
                  end
               end
            end
            MUL: begin
               acc_q <= mul_next;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  state_q     <= IDLE;
                  hi_q        <= mul_fix[2*WIDTH-1:WIDTH];
                  lo_q        <= mul_fix[WIDTH-1:0];
                  out_valid_q <= 1'b1;
                  result_q    <= mul_fix[WIDTH-1:0];
                  ovf_q       <= 1'b0;
                  divzero_q   <= 1'b0;
                  illegal_q   <= 1'b0;
               end
            end
            DIV: begin
               acc_q <= div_next;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  state_q     <= IDLE;
                  hi_q        <= div_rem;
                  lo_q        <= div_quo;
                  out_valid_q <= 1'b1;
                  result_q    <= div_quo;
                  ovf_q       <= 1'b0;
                  divzero_q   <= dz_q;
                  illegal_q   <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares on every out_valid pulse.
module tb_seq_alu;

   localparam int W = 32;

   logic         clk, rst, in_valid, in_ready, out_valid, ovf, divzero, illegal;
   logic [W-1:0] value1, value2, result;
   logic [5:0]   opcode, func;

   typedef struct {
      string        name;
      logic [W-1:0] res;
      logic         ovf;
      logic         dz;
      logic         ill;
      int           due;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .value1(value1), .value2(value2), .opcode(opcode), .func(func),
      .out_valid(out_valid), .result(result), .ovf(ovf),
      .divzero(divzero), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", 64'(out_valid), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".result"},  64'(result),  64'(e.res));
            check({e.name, ".ovf"},     64'(ovf),     64'(e.ovf));
            check({e.name, ".divzero"}, 64'(divzero), 64'(e.dz));
            check({e.name, ".illegal"}, 64'(illegal), 64'(e.ill));
            check({e.name, ".latency"}, 64'(cyc),     64'(e.due));
         end
      end
   end

   task automatic wait_ready(output int n);
      n = 0;
      while (in_ready !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) check("ready_timeout", 64'(in_ready), 64'd1);
   endtask

   task automatic issue(input string nm, input logic [5:0] op, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] r, input logic o, input logic dz,
                        input logic il, input int lat, input bit push);
      int   n;
      exp_t e;
      wait_ready(n);
      opcode = op; func = fn; value1 = a; value2 = b; in_valid = 1'b1;
      if (push) begin
         e.name = nm; e.res = r; e.ovf = o; e.dz = dz; e.ill = il; e.due = cyc + lat;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1; in_valid = 1'b0; value1 = '0; value2 = '0; opcode = '0; func = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.result",    64'(result),    64'd0);
      check("rst.flags",     64'({ovf, divzero, illegal}), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst.in_ready",  64'(in_ready),  64'd1);

      // Single-cycle ops, back-to-back
      issue("add_2_3", 6'd0, 6'd32, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1, 1);
      issue("or_2_3",  6'd0, 6'd37, 32'd2, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0, 1, 1);
      issue("and_2_3", 6'd0, 6'd36, 32'd2, 32'd3, 32'd2, 1'b0, 1'b0, 1'b0, 1, 1);
      issue("add_ovf", 6'd0, 6'd32, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 1'b0, 1'b0, 1, 1);
      issue("addu",    6'd0, 6'd33, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b0, 1'b0, 1, 1);
      issue("sub_ovf", 6'd0, 6'd34, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1, 1);
      issue("slt",     6'd0, 6'd42, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1, 1);
      issue("sltu",    6'd0, 6'd43, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1, 1);
      issue("nor",     6'd0, 6'd39, 32'h0F0F0000, 32'h000000F0, 32'hF0F0FF0F, 1'b0, 1'b0, 1'b0, 1, 1);
      issue("addi_ov", 6'd8, 6'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 1'b0, 1'b0, 1, 1);
      issue("sltiu",   6'd11, 6'd0, 32'd5, 32'd6, 32'd1, 1'b0, 1'b0, 1'b0, 1, 1);
      issue("xori",    6'd14, 6'd0, 32'h0000FFFF, 32'h00000F0F, 32'h0000F0F0, 1'b0, 1'b0, 1'b0, 1, 1);

      // Signed multiply; a request held during MUL must be ignored
      issue("mult", 6'd0, 6'd24, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 1'b0, 1'b0, 1'b0, W+1, 1);
      opcode = 6'd0; func = 6'd32; value1 = 32'd1; value2 = 32'd1; in_valid = 1'b1;
      wait_ready(n);
      in_valid = 1'b0;
      check("mult.busy_cycles", 64'(n), 64'd32);
      issue("mfhi_mult", 6'd0, 6'd16, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1, 1);
      issue("mflo_mult", 6'd0, 6'd18, 32'd0, 32'd0, 32'hFFFFFFFA, 1'b0, 1'b0, 1'b0, 1, 1);

      // Divides
      issue("div_m7_2",  6'd0, 6'd26, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, W+1, 1);
      issue("mfhi_div",  6'd0, 6'd16, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1, 1);
      issue("divu_7_0",  6'd0, 6'd27, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, W+1, 1);
      issue("mfhi_dz",   6'd0, 6'd16, 32'd0, 32'd0, 32'd7, 1'b0, 1'b0, 1'b0, 1, 1);
      issue("div_minm1", 6'd0, 6'd26, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b0, W+1, 1);
      issue("mfhi_minm1",6'd0, 6'd16, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1, 1);
      issue("divu_100_7",6'd0, 6'd27, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b0, W+1, 1);
      issue("mfhi_100_7",6'd0, 6'd16, 32'd0, 32'd0, 32'd2, 1'b0, 1'b0, 1'b0, 1, 1);

      // Unsigned full-range multiply, then illegal ops leave HI/LO intact
      issue("multu_max", 6'd0, 6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, W+1, 1);
      issue("ill_fn63",  6'd0, 6'd63, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 1'b1, 1, 1);
      @(posedge clk); #1;
      check("ill.hold_out_valid", 64'(out_valid), 64'd0);
      check("ill.hold_illegal",   64'(illegal),   64'd1);
      issue("ill_op2",   6'd2, 6'd0, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 1'b1, 1, 1);
      issue("mfhi_ill",  6'd0, 6'd16, 32'd0, 32'd0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1, 1);
      issue("mflo_ill",  6'd0, 6'd18, 32'd0, 32'd0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1, 1);

      // Reset at cycle 10 of a mult aborts it silently
      issue("mult_rst", 6'd0, 6'd24, 32'd5, 32'd6, 32'd0, 1'b0, 1'b0, 1'b0, W+1, 0);
      repeat (9) @(posedge clk);
      #1;
      check("abort.busy", 64'(in_ready), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort.in_ready",  64'(in_ready),  64'd1);
      check("abort.out_valid", 64'(out_valid), 64'd0);
      repeat (40) @(posedge clk);
      #1;
      issue("mflo_rst", 6'd0, 6'd18, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1, 1);
      issue("mfhi_rst", 6'd0, 6'd16, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1, 1);

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
